// File: rtl/sound_latch_mailbox.sv
// 68k <-> Z80 sound mailbox: a command latch toward the Z80 with an interrupt request,
// and a reply latch back to the 68k. Every strobe is edge-detected and every output is registered.
module sound_latch_mailbox #(
    parameter int unsigned LATCH_HI    = 1,
    parameter int unsigned IRQ_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m68k_latch_cs,
    input  logic        z80_latch_read_cs,
    input  logic [15:0] m68k_dout,
    input  logic        m68k_uds_n,
    input  logic        m68k_lds_n,
    input  logic        z80_latch_cs,
    input  logic        z80_rd_n,
    input  logic        z80_wr_n,
    input  logic        M1_n,
    input  logic        IORQ_n,
    input  logic [7:0]  z80_dout,
    output logic [7:0]  sound_latch,
    output logic [15:0] reply_latch,
    output logic        z80_irq_n,
    output logic        sound_full,
    output logic        reply_full
);

    localparam int unsigned CntW = (IRQ_TIMEOUT > 0) ? $clog2(IRQ_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((IRQ_TIMEOUT > 0) ? IRQ_TIMEOUT - 1 : 0);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    typedef enum logic {StIdle, StPend} irq_state_e;

    irq_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      sound_q, sound_d;
    logic [7:0]      reply_q, reply_d;
    logic            sound_full_q, sound_full_d;
    logic            reply_full_q, reply_full_d;

    // Level strobes and their one-clock history
    logic m68k_wr, z80_wr, z80_rd, ack;
    logic m68k_wr_q, z80_wr_q, z80_rd_q, m68k_rd_q, ack_q;
    logic m68k_wr_edge, z80_wr_edge, z80_rd_edge, m68k_rd_edge, ack_edge;
    logic [7:0] m68k_byte;

    assign m68k_wr   = m68k_latch_cs & ((LATCH_HI != 0) ? ~m68k_uds_n : ~m68k_lds_n);
    assign m68k_byte = (LATCH_HI != 0) ? m68k_dout[15:8] : m68k_dout[7:0];
    assign z80_wr    = z80_latch_cs & ~z80_wr_n;
    assign z80_rd    = z80_latch_cs & ~z80_rd_n;
    assign ack       = ~M1_n & ~IORQ_n;

    assign m68k_wr_edge = m68k_wr & ~m68k_wr_q;
    assign z80_wr_edge  = z80_wr & ~z80_wr_q;
    assign z80_rd_edge  = z80_rd & ~z80_rd_q;
    assign m68k_rd_edge = z80_latch_read_cs & ~m68k_rd_q;
    assign ack_edge     = ack & ~ack_q;

    always_comb begin
        sound_d      = sound_q;
        sound_full_d = sound_full_q;
        reply_d      = reply_q;
        reply_full_d = reply_full_q;
        // Writes are applied after reads so a coincident write leaves the flag set
        if (z80_rd_edge) sound_full_d = 1'b0;
        if (m68k_wr_edge) begin
            sound_d      = m68k_byte;
            sound_full_d = 1'b1;
        end
        if (m68k_rd_edge) reply_full_d = 1'b0;
        if (z80_wr_edge) begin
            reply_d      = z80_dout;
            reply_full_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: cnt_d = '0;
            StPend: begin
                if (IRQ_TIMEOUT > 0 && cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                if (ack_edge || (IRQ_TIMEOUT > 0 && cnt_q == CntLast)) state_d = StIdle;
            end
        endcase
        // A fresh request beats a coincident acknowledge or timeout
        if (m68k_wr_edge) begin
            state_d = StPend;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sound_q      <= 8'h00;
            reply_q      <= 8'h00;
            sound_full_q <= 1'b0;
            reply_full_q <= 1'b0;
            m68k_wr_q    <= 1'b0;
            z80_wr_q     <= 1'b0;
            z80_rd_q     <= 1'b0;
            m68k_rd_q    <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sound_q      <= sound_d;
            reply_q      <= reply_d;
            sound_full_q <= sound_full_d;
            reply_full_q <= reply_full_d;
            m68k_wr_q    <= m68k_wr;
            z80_wr_q     <= z80_wr;
            z80_rd_q     <= z80_rd;
            m68k_rd_q    <= z80_latch_read_cs;
            ack_q        <= ack;
        end
    end

    assign sound_latch = sound_q;
    assign reply_latch = {reply_q, reply_q};
    assign z80_irq_n   = (state_q == StIdle);
    assign sound_full  = sound_full_q;
    assign reply_full  = reply_full_q;

endmodule
